pulse_stretcher_fsm: RTL

Converts a single-cycle tick into a clean level pulse of programmable length, the level-generating counterpart to the tick-producing edge detectors in the MMIO misc cores. It is a Moore FSM with a down-counter, optional retrigger and a post-pulse hold-off. It drives LED blink, buzzer enable and strobe-style outputs from timer or GPIO ticks. The `tick` input is expected to be a one-cycle pulse already synchronous to `clk`.

---
 rtl/pulse_stretcher_fsm_pkg.sv | 13 +
 rtl/pulse_stretcher_fsm.sv | 83 ++++++++
 2 files changed

// File: rtl/pulse_stretcher_fsm_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and default counter width.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned W_DEFAULT = 16;

endpackage

// File: rtl/pulse_stretcher_fsm.sv
// Moore pulse stretcher: turns a one-cycle tick into a level pulse of len cycles,
// with optional retrigger and a post-pulse hold-off during which ticks are ignored.
module pulse_stretcher_fsm
  import pulse_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] len,
  input  logic         retrig_en,
  output logic         level,
  output logic         done_tick,
  output logic         busy
);

  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_HOLD = W'(HOLDOFF);

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic         len_ok;

  assign len_ok = (len != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (tick && len_ok) begin
          state_n = HIGH;
          cnt_n   = len;
        end
      end
      HIGH: begin
        // Retrigger is checked first so a tick on the last high cycle extends the pulse.
        if (retrig_en && tick && len_ok) begin
          cnt_n = len;
        end else if (cnt == CNT_ONE) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DONE: begin
        if (HOLDOFF == 0) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
          cnt_n   = CNT_HOLD;
        end
      end
      HOLD: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign level     = (state == HIGH);
  assign done_tick = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
